// File: rtl/uart_reg_bridge_if.sv
// Byte-stream and register-bus signals between the UART FIFOs, the command
// bridge and the on-chip register file.
interface uart_reg_bridge_if;
    logic       rx_empty;
    logic [7:0] rx_data;
    logic       rd_uart;
    logic       tx_full;
    logic       wr_uart;
    logic [7:0] w_data;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;

    modport master (
        input  rx_empty, rx_data, tx_full, reg_rdata,
        output rd_uart, wr_uart, w_data, reg_addr, reg_wdata, reg_we, reg_re
    );

    modport slave (
        output rx_empty, rx_data, tx_full, reg_rdata,
        input  rd_uart, wr_uart, w_data, reg_addr, reg_wdata, reg_we, reg_re
    );
endinterface

// File: rtl/uart_reg_bridge.sv
// Decodes SYNC/CMD/ADDR/[DATA]/CSUM frames from the UART RX FIFO into register
// reads/writes and answers with ACK (+data) or NAK through the TX FIFO.
module uart_reg_bridge #(
    parameter logic [7:0] SYNC    = 8'h55,
    parameter logic [7:0] ACK     = 8'hAC,
    parameter logic [7:0] NAK     = 8'hEE,
    parameter int         TIMEOUT = 100000
) (
    input  logic              clk,
    input  logic              reset,
    uart_reg_bridge_if.master bus,
    output logic              busy,
    output logic [7:0]        err_cnt
);
    localparam logic [31:0] TMO = 32'(TIMEOUT);

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_ADDR, S_DATA, S_CSUM,
        S_EXEC, S_RD_WAIT, S_TX_ACK, S_TX_DATA, S_TX_NAK
    } state_t;

    state_t      r_state, w_next;
    logic [7:0]  r_cmd, r_addr, r_data, r_rdata;
    logic [7:0]  r_reg_addr, r_reg_wdata, r_err;
    logic [31:0] r_tmo;
    logic        r_ok;

    logic        w_in_frame, w_recv, w_pop, w_tmo_fire, w_is_wr, w_is_rd, w_good, w_err_inc;
    logic        w_wr, w_we, w_re;
    logic [7:0]  w_sum, w_byte;

    assign w_in_frame = (r_state == S_CMD) || (r_state == S_ADDR) ||
                        (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_recv     = w_in_frame || (r_state == S_IDLE);
    // Gated by reset so the comb pop cannot fire while the FIFO sees an idle bridge held in reset.
    assign w_pop      = w_recv && !bus.rx_empty && reset;
    assign w_tmo_fire = w_in_frame && bus.rx_empty && (TIMEOUT != 0) && (r_tmo == TMO);
    assign w_is_wr    = (r_cmd == 8'h01);
    assign w_is_rd    = (r_cmd == 8'h02);
    assign w_sum      = r_cmd ^ r_addr ^ (w_is_wr ? r_data : 8'h00);
    assign w_good     = (bus.rx_data == w_sum) && (w_is_wr || w_is_rd);
    assign w_err_inc  = ((r_state == S_EXEC) && !r_ok) || w_tmo_fire;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_wr   = 1'b0;
        w_we   = 1'b0;
        w_re   = 1'b0;
        w_byte = 8'h00;
        case (r_state)
            S_IDLE:    if (w_pop && bus.rx_data == SYNC) w_next = S_CMD;
            S_CMD:     if (w_pop) w_next = S_ADDR;
                       else if (w_tmo_fire) w_next = S_IDLE;
            S_ADDR:    if (w_pop) w_next = w_is_wr ? S_DATA : S_CSUM;
                       else if (w_tmo_fire) w_next = S_IDLE;
            S_DATA:    if (w_pop) w_next = S_CSUM;
                       else if (w_tmo_fire) w_next = S_IDLE;
            S_CSUM:    if (w_pop) w_next = S_EXEC;
                       else if (w_tmo_fire) w_next = S_IDLE;
            S_EXEC: begin
                if (!r_ok)        w_next = S_TX_NAK;
                else if (w_is_wr) begin w_we = 1'b1; w_next = S_TX_ACK; end
                else              begin w_re = 1'b1; w_next = S_RD_WAIT; end
            end
            S_RD_WAIT: w_next = S_TX_ACK;
            S_TX_ACK: begin
                w_byte = ACK;
                if (!bus.tx_full) begin
                    w_wr   = 1'b1;
                    w_next = w_is_rd ? S_TX_DATA : S_IDLE;
                end
            end
            S_TX_DATA: begin
                w_byte = r_rdata;
                if (!bus.tx_full) begin w_wr = 1'b1; w_next = S_IDLE; end
            end
            S_TX_NAK: begin
                w_byte = NAK;
                if (!bus.tx_full) begin w_wr = 1'b1; w_next = S_IDLE; end
            end
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cmd       <= 8'h00;
            r_addr      <= 8'h00;
            r_data      <= 8'h00;
            r_rdata     <= 8'h00;
            r_reg_addr  <= 8'h00;
            r_reg_wdata <= 8'h00;
            r_err       <= 8'h00;
            r_tmo       <= 32'd0;
            r_ok        <= 1'b0;
        end else begin
            if (w_pop) begin
                case (r_state)
                    S_CMD:  r_cmd  <= bus.rx_data;
                    S_ADDR: r_addr <= bus.rx_data;
                    S_DATA: r_data <= bus.rx_data;
                    S_CSUM: begin
                        // Bus address/data are committed only for frames that will strobe.
                        r_ok <= w_good;
                        if (w_good) begin
                            r_reg_addr <= r_addr;
                            if (w_is_wr) r_reg_wdata <= r_data;
                        end
                    end
                    default: ;
                endcase
            end
            if (r_state == S_RD_WAIT) r_rdata <= bus.reg_rdata;
            if (w_in_frame && TIMEOUT != 0) begin
                if (w_pop)             r_tmo <= 32'd0;
                else if (bus.rx_empty) r_tmo <= r_tmo + 32'd1;
            end else begin
                r_tmo <= 32'd0;
            end
            if (w_err_inc && r_err != 8'hFF) r_err <= r_err + 8'd1;
        end
    end

    assign bus.rd_uart   = w_pop;
    assign bus.wr_uart   = w_wr;
    assign bus.w_data    = w_byte;
    assign bus.reg_we    = w_we;
    assign bus.reg_re    = w_re;
    assign bus.reg_addr  = r_reg_addr;
    assign bus.reg_wdata = r_reg_wdata;
    assign busy          = (r_state != S_IDLE);
    assign err_cnt       = r_err;
endmodule
